// File: rtl/axi8_lite_arbiter.sv
// Round-robin master for the 8-bit AXI-lite processing slave: writes the
// winner's byte to addr 0, reads the result from addr 1, and returns it.
module axi8_lite_arbiter #(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   rsp_valid,
  input  logic [N_REQ-1:0]   rsp_ready,
  output logic [7:0]         rsp_data,
  output logic               rsp_err,
  output logic               busy,
  output logic [1:0]         grant,
  output logic               m_awvalid,
  output logic               m_wvalid,
  output logic               m_bready,
  output logic               m_arvalid,
  output logic               m_rready,
  output logic               m_addr,
  output logic               m_wstrb,
  output logic [7:0]         m_wdata,
  input  logic               m_awready,
  input  logic               m_wready,
  input  logic               m_bvalid,
  input  logic               m_arready,
  input  logic               m_rvalid,
  input  logic [7:0]         m_rdata
);

  typedef enum logic [2:0] {ST_IDLE, ST_AWW, ST_B, ST_AR, ST_R, ST_RSP} state_t;

  state_t           state_q;
  logic [1:0]       last_q, grant_q;
  logic [7:0]       cnt_q;
  logic [7:0]       wdata_q, rsp_data_q;
  logic             rsp_err_q;
  logic [N_REQ-1:0] rsp_valid_q;
  logic             awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic             addr_q, wstrb_q;

  logic             win_vld_d;
  logic [1:0]       win_idx_d;
  logic [7:0]       win_byte_d;
  int               cand;
  logic             phase_done, in_phase, timeout_hit, rsp_ack;

  // Search downward so the nearest index after last_q is the final assignment.
  always_comb begin
    win_vld_d  = 1'b0;
    win_idx_d  = '0;
    win_byte_d = '0;
    cand       = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = (int'(last_q) + k) % N_REQ;
      if ((req_valid & (N_REQ'(1) << cand)) != '0) begin
        win_vld_d = 1'b1;
        win_idx_d = cand[1:0];
      end
    end
    for (int i = 0; i < N_REQ; i++)
      if (win_idx_d == 2'(i)) win_byte_d = req_data[8*i +: 8];
  end

  always_comb begin
    phase_done = 1'b0;
    case (state_q)
      ST_AWW:  phase_done = (!awvalid_q || m_awready) && (!wvalid_q || m_wready);
      ST_B:    phase_done = bready_q && m_bvalid;
      ST_AR:   phase_done = arvalid_q && m_arready;
      ST_R:    phase_done = rready_q && m_rvalid;
      default: phase_done = 1'b0;
    endcase
  end

  assign in_phase = (state_q == ST_AWW) || (state_q == ST_B) ||
                    (state_q == ST_AR)  || (state_q == ST_R);
  // A phase that completes on its last allowed cycle is not aborted.
  assign timeout_hit = in_phase && !phase_done && ((cnt_q + 8'd1) == 8'(TIMEOUT));
  assign rsp_ack     = |(rsp_ready & rsp_valid_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      last_q      <= 2'(N_REQ - 1);
      grant_q     <= '0;
      cnt_q       <= '0;
      wdata_q     <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      addr_q      <= 1'b0;
      wstrb_q     <= 1'b0;
    end else begin
      if (in_phase) cnt_q <= cnt_q + 8'd1;
      if (timeout_hit) begin
        awvalid_q   <= 1'b0;
        wvalid_q    <= 1'b0;
        bready_q    <= 1'b0;
        arvalid_q   <= 1'b0;
        rready_q    <= 1'b0;
        wstrb_q     <= 1'b0;
        rsp_data_q  <= 8'h00;
        rsp_err_q   <= 1'b1;
        rsp_valid_q <= N_REQ'(1) << grant_q;
        cnt_q       <= '0;
        state_q     <= ST_RSP;
      end else begin
        case (state_q)
          ST_IDLE: if (win_vld_d) begin
            wdata_q   <= win_byte_d;
            grant_q   <= win_idx_d;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            addr_q    <= 1'b0;
            wstrb_q   <= 1'b1;
            cnt_q     <= '0;
            state_q   <= ST_AWW;
          end
          ST_AWW: begin
            if (awvalid_q && m_awready) awvalid_q <= 1'b0;
            if (wvalid_q && m_wready)   wvalid_q  <= 1'b0;
            if (phase_done) begin
              wstrb_q  <= 1'b0;
              bready_q <= 1'b1;
              cnt_q    <= '0;
              state_q  <= ST_B;
            end
          end
          ST_B: if (phase_done) begin
            bready_q  <= 1'b0;
            arvalid_q <= 1'b1;
            addr_q    <= 1'b1;
            cnt_q     <= '0;
            state_q   <= ST_AR;
          end
          ST_AR: if (phase_done) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            cnt_q     <= '0;
            state_q   <= ST_R;
          end
          ST_R: if (phase_done) begin
            rready_q    <= 1'b0;
            rsp_data_q  <= m_rdata;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= N_REQ'(1) << grant_q;
            cnt_q       <= '0;
            state_q     <= ST_RSP;
          end
          ST_RSP: if (rsp_ack) begin
            rsp_valid_q <= '0;
            last_q      <= grant_q;
            state_q     <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign req_ready = (state_q == ST_IDLE && win_vld_d) ? (N_REQ'(1) << win_idx_d) : '0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != ST_IDLE);
  assign grant     = grant_q;
  assign m_awvalid = awvalid_q;
  assign m_wvalid  = wvalid_q;
  assign m_bready  = bready_q;
  assign m_arvalid = arvalid_q;
  assign m_rready  = rready_q;
  assign m_addr    = addr_q;
  assign m_wstrb   = wstrb_q;
  assign m_wdata   = wdata_q;

endmodule

// File: tb/tb_axi8_lite_arbiter.sv
// Bench for axi8_lite_arbiter: a delay-programmable slave plus a per-transaction
// timeline model that predicts every control, grant and response cycle.
module tb_axi8_lite_arbiter;
  localparam int N = 3, TO = 8, NEVER = 1000;

  logic clk = 1'b0, rst;
  logic [N-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [8*N-1:0] req_data;
  logic [7:0] rsp_data, m_wdata, m_rdata;
  logic rsp_err, busy, m_addr, m_wstrb;
  logic [1:0] grant;
  logic m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic m_awready, m_wready, m_bvalid, m_arready, m_rvalid;

  always #5 clk = ~clk;

  axi8_lite_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .grant(grant),
    .m_awvalid(m_awvalid), .m_wvalid(m_wvalid), .m_bready(m_bready),
    .m_arvalid(m_arvalid), .m_rready(m_rready), .m_addr(m_addr),
    .m_wstrb(m_wstrb), .m_wdata(m_wdata), .m_awready(m_awready),
    .m_wready(m_wready), .m_bvalid(m_bvalid), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata));

  int errs = 0, checks = 0, cyc = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // stimulus knobs
  logic [N-1:0] pend = '0, hold = '0;
  logic [7:0]   pbyte [N];
  bit vrand = 0, rrand = 0, ddly = 0, do_rst = 0, jrst = 0;
  int fx [5] = '{default: 0};
  int bp_left = 0;

  // reference model: one in-flight transaction described by its phase timeline
  bit mb = 0;
  int own, acc, rspk, ab, last = N - 1, mgrant = 0, done = 0, hold_len = 0, rdyn = 0;
  int dl [5], dur [4];
  logic [7:0] mbyte;
  logic [8:0] lastrsp;
  int gq [$];
  logic [8:0] dq [$];

  // slave state
  int cn [5];
  int hsn [5];
  logic [7:0] stor = '0;

  function automatic logic [N-1:0] onehot(int i);
    return N'(1) << i;
  endfunction

  // Expected {awvalid,wvalid,bready,arvalid,rready} at cycle k after acceptance.
  function automatic logic [4:0] ctrl_exp(int k);
    int t;
    t = k;
    for (int p = 0; p < 4; p++) begin
      if (t <= dur[p]) begin
        case (p)
          0: return {t <= dl[0] + 1, t <= dl[1] + 1, 3'b000};
          1: return 5'b00100;
          2: return 5'b00010;
          default: return 5'b00001;
        endcase
      end
      if (p == ab) return 5'b00000;
      t -= dur[p];
    end
    return 5'b00000;
  endfunction

  task automatic accept(int w);
    int need [4];
    mb = 1; own = w; acc = cyc; mbyte = pbyte[w];
    gq.push_back(w);
    for (int p = 0; p < 5; p++)
      dl[p] = !ddly ? fx[p] :
              ($urandom_range(9) == 0) ? 7 + int'($urandom_range(2)) : int'($urandom_range(3));
    need[0] = ((dl[0] > dl[1]) ? dl[0] : dl[1]) + 1;
    need[1] = dl[2] + 1;
    need[2] = dl[3] + 1;
    need[3] = dl[4] + 1;
    ab = 4; rspk = 1;
    for (int p = 0; p < 4; p++) begin
      dur[p] = 0;
      if (ab == 4) begin
        dur[p] = (need[p] > TO) ? TO : need[p];
        rspk += dur[p];
        if (need[p] > TO) ab = p;
      end
    end
    for (int p = 0; p < 5; p++) cn[p] = 0;
    if (!hold[w]) pend[w] = 1'b0;
  endtask

  task automatic cycle();
    logic [4:0] sc, ec;
    logic [N-1:0] rv, rr;
    int k, w;
    @(negedge clk);
    cyc++;
    sc = {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready};
    k = mb ? cyc - acc : 0;
    if (jrst) begin
      chk("rst_out", 32'({busy, grant, sc, rsp_valid, rsp_data, rsp_err, m_addr, m_wstrb, m_wdata}), 32'd0);
      jrst = 0;
    end
    if (mb) begin
      ec = ctrl_exp(k);
      chk("ctrl", 32'(sc), 32'(ec));
      chk("busy", 32'(busy), 32'd1);
      chk("grant", 32'(grant), own);
      if (ec[4] | ec[3]) chk("aww_bus", 32'({m_addr, m_wstrb, m_wdata}), 32'({2'b01, mbyte}));
      if (ec[1]) chk("ar_addr", 32'(m_addr), 32'd1);
      chk("rsp_valid", 32'(rsp_valid), 32'((k >= rspk) ? onehot(own) : '0));
      if (k >= rspk)
        chk("rsp", 32'({rsp_err, rsp_data}), 32'((ab < 4) ? 9'h100 : {1'b0, ~mbyte}));
    end else begin
      chk("idle", 32'({busy, sc, rsp_valid}), 32'd0);
      chk("grant_idle", 32'(grant), mgrant);
    end
    // drive requesters
    for (int i = 0; i < N; i++) begin
      rv[i] = pend[i] && (!vrand || $urandom_range(3) != 0);
      req_data[8*i +: 8] = pbyte[i];
    end
    req_valid = rv;
    rr = rrand ? N'($urandom) : '1;
    if (bp_left > 0 && mb && k >= rspk) begin
      rr[own] = 1'b0;
      bp_left--;
    end
    rsp_ready = rr;
    // drive slave
    m_awready = m_awvalid && cn[0] == dl[0]; if (m_awvalid) cn[0]++;
    m_wready  = m_wvalid  && cn[1] == dl[1]; if (m_wvalid)  cn[1]++;
    m_bvalid  = m_bready  && cn[2] == dl[2]; if (m_bready)  cn[2]++;
    m_arready = m_arvalid && cn[3] == dl[3]; if (m_arvalid) cn[3]++;
    m_rvalid  = m_rready  && cn[4] == dl[4]; if (m_rready)  cn[4]++;
    if (m_awvalid && m_awready) hsn[0]++;
    if (m_wvalid && m_wready) begin hsn[1]++; stor = m_wdata; end
    if (m_bready && m_bvalid) hsn[2]++;
    if (m_arvalid && m_arready) hsn[3]++;
    if (m_rready && m_rvalid) hsn[4]++;
    m_rdata = ~stor;
    rst = do_rst;
    #1;
    if (req_ready != '0) rdyn++;
    if (do_rst) begin
      mb = 0; last = N - 1; mgrant = 0; jrst = 1; do_rst = 0;
    end else if (!mb) begin
      w = -1;
      for (int j = 1; j <= N; j++)
        if (w < 0 && rv[(last + j) % N]) w = (last + j) % N;
      chk("req_ready", 32'(req_ready), 32'((w >= 0) ? onehot(w) : '0));
      if (w >= 0) accept(w);
    end else begin
      chk("req_ready_busy", 32'(req_ready), 32'd0);
      if (k >= rspk && rr[own]) begin
        mb = 0; last = own; mgrant = own; done++;
        hold_len = k - rspk;
        lastrsp = {rsp_err, rsp_data};
        dq.push_back(lastrsp);
      end
    end
  endtask

  task automatic run_until_done(int n, int maxc);
    int t, target;
    t = 0; target = done + n;
    while (done < target && t < maxc) begin cycle(); t++; end
    chk("done_bound", 32'(done >= target), 32'd1);
  endtask

  task automatic wait_busy(int maxc);
    int t;
    t = 0;
    while (!mb && t < maxc) begin cycle(); t++; end
    chk("busy_bound", 32'(mb), 32'd1);
  endtask

  task automatic clr_stats();
    gq.delete(); dq.delete(); rdyn = 0;
    for (int p = 0; p < 5; p++) hsn[p] = 0;
  endtask

  initial begin
    int t;
    for (int i = 0; i < N; i++) pbyte[i] = 8'h00;
    for (int p = 0; p < 5; p++) begin dl[p] = 0; cn[p] = 0; hsn[p] = 0; end
    for (int p = 0; p < 4; p++) dur[p] = 0;
    rst = 1'b1; req_valid = '0; req_data = '0; rsp_ready = '0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0; m_rdata = '0;
    repeat (2) @(posedge clk);
    do_rst = 1;
    cycle();
    cycle();

    // single request with an ideal slave
    clr_stats();
    pbyte[0] = 8'h5A; pend[0] = 1;
    run_until_done(1, 50);
    chk("single_rsp", 32'(lastrsp), 32'h0A5);
    chk("single_rdy_pulses", rdyn, 1);
    chk("single_hs", 32'({hsn[0] == 1, hsn[1] == 1, hsn[2] == 1, hsn[3] == 1, hsn[4] == 1}), 32'h1F);

    // W accepted three cycles before AW
    clr_stats();
    fx = '{3, 0, 0, 0, 0};
    pbyte[1] = 8'h3C; pend[1] = 1;
    run_until_done(1, 50);
    chk("stagger_rsp", 32'(lastrsp), 32'h0C3);
    chk("stagger_hs", 32'({hsn[0], hsn[1]}), 32'({32'd1, 32'd1}));
    fx = '{0, 0, 0, 0, 0};

    // continuous requests from 0 and 1 alternate
    clr_stats();
    hold[0] = 1; hold[1] = 1; pbyte[0] = 8'h00; pbyte[1] = 8'hFF; pend[0] = 1; pend[1] = 1;
    run_until_done(4, 100);
    hold = '0; pend = '0;
    chk("rr_grants", 32'({gq[0], gq[1], gq[2], gq[3]} == {32'd0, 32'd1, 32'd0, 32'd1}), 32'd1);
    chk("rr_data", 32'({dq[0], dq[1], dq[2], dq[3]}), 32'({9'h0FF, 9'h000, 9'h0FF, 9'h000}));

    // B never answers: abort then a clean transaction
    fx = '{0, 0, NEVER, 0, 0};
    pbyte[0] = 8'h77; pend[0] = 1;
    run_until_done(1, 50);
    chk("timeout_rsp", 32'(lastrsp), 32'h100);
    fx = '{0, 0, 0, 0, 0};
    pbyte[0] = 8'h12; pend[0] = 1;
    run_until_done(1, 50);
    chk("after_timeout_rsp", 32'(lastrsp), 32'h0ED);

    // response held off for 10 cycles while requester 0 waits
    clr_stats();
    pbyte[1] = 8'h44; pend[1] = 1;
    wait_busy(20);
    pbyte[0] = 8'h99; pend[0] = 1; bp_left = 10;
    run_until_done(1, 60);
    chk("bp_rsp", 32'(lastrsp), 32'h0BB);
    chk("bp_hold", 32'(hold_len >= 10), 32'd1);
    run_until_done(1, 60);
    chk("bp_next", 32'(lastrsp), 32'h066);

    // reset during the read-address phase
    fx = '{0, 0, 0, 3, 0};
    pbyte[2] = 8'h21; pend[2] = 1;
    t = 0;
    while (!(mb && cyc - acc == 3) && t < 100) begin cycle(); t++; end
    chk("reach_ar", 32'(mb), 32'd1);
    fx = '{0, 0, 0, 0, 0};
    clr_stats();
    pbyte[0] = 8'h81; pbyte[2] = 8'h21; pend[0] = 1; pend[2] = 1;
    do_rst = 1;
    cycle();
    run_until_done(2, 100);
    chk("rst_first_grant", gq[0], 0);
    chk("rst_second_grant", gq[1], 2);
    chk("rst_data", 32'({dq[0], dq[1]}), 32'({9'h07E, 9'h0DE}));

    // randomized traffic, delays and backpressure
    vrand = 1; rrand = 1; ddly = 1;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(3) == 0) begin
          pend[i] = 1'b1;
          pbyte[i] = 8'($urandom);
        end
      cycle();
    end
    pend = '0; vrand = 0; rrand = 0;
    t = 0;
    while (mb && t < 200) begin cycle(); t++; end
    chk("drain", 32'(mb), 32'd0);
    chk("random_progress", 32'(done > 100), 32'd1);
    cycle();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/axi8_lite_arbiter.md
Name: axi8_lite_arbiter

Overview:
- Master-side controller that shares the 8-bit AXI-lite processing slave (tt_um_axi8_lite_proc) between N_REQ requesters.
- Arbitrates round-robin and runs the full transaction for the winner: write the byte to address 0 (AW/W/B), then read address 1 (AR/R).
- Returns the read byte, the slave's inverted result, to the winning requester.
- A watchdog aborts any phase that stalls and returns an error response instead.

Parameters:
- N_REQ, 2, number of requesters (2..4).
- TIMEOUT, 255, maximum cycles spent in one bus phase before abort (1..255, 8-bit counter).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  N_REQ  requester i has a byte to process.
- req_data  in  8*N_REQ  byte of requester i, in bits [8i+7:8i].
- req_ready  out  N_REQ  request accepted this cycle (one-hot).
- rsp_valid  out  N_REQ  response pending for requester i (one-hot).
- rsp_ready  in  N_REQ  requester i consumes its response.
- rsp_data  out  8  result byte, shared by all requesters.
- rsp_err  out  1  response is a timeout abort.
- busy  out  1  state is not IDLE.
- grant  out  2  index of the current or last owner.
- m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready  out  1 each  AXI-lite master controls.
- m_addr  out  1  0 = input register, 1 = output register.
- m_wstrb  out  1  write strobe.
- m_wdata  out  8  write data.
- m_awready, m_wready, m_bvalid, m_arready, m_rvalid  in  1 each  slave handshakes.
- m_rdata  in  8  read data.

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - last_grant = N_REQ-1, so index 0 wins first.
  - Timeout counter 0.
  - Reset mid-transaction drops every valid on the next edge; no response is issued.
- Handshake rule: a transfer completes at a posedge where valid & ready are both 1. The controller holds valid, m_addr and m_wdata stable until that edge.
- States: IDLE, AWW, B, AR, R, RSP.
- IDLE:
  - Winner = first i with req_valid[i], searching cyclically from last_grant+1.
  - req_ready[winner] = 1 combinationally in the same cycle.
  - At the edge: latch req_data[winner], set grant = winner, enter AWW.
  - No req_valid means stay in IDLE with req_ready = 0.
- AWW:
  - m_addr = 0, m_wstrb = 1.
  - m_awvalid and m_wvalid are both raised on entry.
  - Each drops independently after its own handshake; both may complete in the same cycle, in either order.
  - Enter B once both have completed.
- B: m_bready = 1. On the m_bvalid handshake, enter AR.
- AR: m_addr = 1, m_arvalid = 1. On the m_arready handshake, enter R.
- R: m_rready = 1. On the m_rvalid handshake, latch m_rdata into rsp_data, clear rsp_err, enter RSP.
- RSP:
  - rsp_valid[grant] = 1; rsp_data and rsp_err are held.
  - On rsp_ready[grant]: rsp_valid drops, last_grant = grant, enter IDLE.
  - The next request can be accepted no earlier than the cycle after.
  - rsp_ready on a non-granted index is ignored.
- Watchdog:
  - The counter clears on every state entry and increments each cycle spent in AWW, B, AR or R.
  - When it reaches TIMEOUT, all m_* valids/readies drop at that edge; rsp_err = 1, rsp_data = 0x00, enter RSP.
  - A handshake and a timeout on the same edge: the handshake wins.
- Controller overhead: 1 cycle per phase when the slave responds immediately. From req_ready to rsp_valid is 5 cycles minimum (AWW, B, AR, R, then RSP).
- Requests that arrive while busy wait, with req_ready = 0.
- A requester that drops req_valid before grant loses its place without error.

Test Plan:
- Single request: req 0 sends 0x5A with an ideal slave -> req_ready[0] pulses once; m_awvalid/m_wvalid carry m_wdata = 0x5A, m_addr = 0; then m_arvalid with m_addr = 1; rsp_valid[0] with rsp_data = 0xA5, rsp_err = 0; exactly one of each handshake.
- Round robin: req 0 = 0x00 and req 1 = 0xFF held continuously -> grants alternate 0, 1, 0, 1; responses 0xFF, 0x00 alternate.
- Staggered readies: slave asserts m_wready 3 cycles before m_awready -> m_wvalid drops after the W handshake while m_awvalid stays high; B is not entered until AW completes; data is still correct.
- Timeout: slave never asserts m_bvalid, TIMEOUT = 8 -> after 8 cycles in B, m_bready drops; rsp_valid with rsp_err = 1, rsp_data = 0x00; next request completes normally.
- Response backpressure: rsp_ready[1] held low for 10 cycles -> rsp_valid[1] and rsp_data stay stable; no new req_ready for other requesters until consumed.
- Reset in AR: assert rst for 1 cycle -> all outputs 0 next edge; state IDLE; requester 0 wins the next arbitration.
